// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by the ALU stream core
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SLL, OP_SRL, OP_ROL, OP_ROR,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
  } op_e;
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_e;
endpackage

// File: rtl/alu_divider.sv
// alu_divider: restoring divider, one quotient bit per cycle (start loads a/b; done high during the final iteration; quo/rem valid the cycle after)
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] trial;
  logic ge;
  assign trial = {rem, quo[WIDTH-1]};
  assign ge = trial >= {1'b0, dvs};
  assign done = cnt == CW'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      quo <= a;
      rem <= '0;
      dvs <= b;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      rem <= ge ? trial[WIDTH-1:0] - dvs : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ge};
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/alu_stream_core.sv
// alu_stream_core: handshaked tagged ALU (in_valid/in_ready/in_op/in_a/in_b/in_tag in; out_valid/out_ready/out_result/out_tag/out_ovf/out_dbz out; busy) with iterative divider and in-order output FIFO
module alu_stream_core import alu_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  op_e                in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_ovf,
  output logic               out_dbz,
  output logic               busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  typedef struct packed {
    logic [2*WIDTH-1:0] result;
    logic [TAG_W-1:0]   tag;
    logic               ovf;
    logic               dbz;
  } result_t;
  function automatic logic [2*WIDTH-1:0] zx(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction
  state_e state;
  result_t mem [FIFO_DEPTH];
  result_t pend, alu_ent, div_ent, head;
  logic pend_valid, accept, div_start, div_done, push, pop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [TAG_W-1:0] div_tag;
  logic [WIDTH-1:0] div_q, div_r;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] rl, rr;
  logic [SHW-1:0] sh;
  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .reset(reset), .start(div_start), .a(in_a), .b(in_b),
    .done(div_done), .quo(div_q), .rem(div_r)
  );
  // pend_valid counts as in-flight so a pushed result always has a free slot
  assign in_ready = reset && state == IDLE && (count + (PW+1)'(pend_valid) < DEPTH_C);
  assign accept = in_valid && in_ready;
  assign div_start = accept && in_op == OP_DIV && in_b != '0;
  assign push = pend_valid || state == DIV_DONE;
  assign pop = out_valid && out_ready;
  assign out_valid = count != '0;
  assign head = out_valid ? mem[rd_ptr] : '0;
  assign out_result = head.result;
  assign out_tag = head.tag;
  assign out_ovf = head.ovf;
  assign out_dbz = head.dbz;
  assign busy = state != IDLE || pend_valid || out_valid;
  assign div_ent = '{result: {div_r, div_q}, tag: div_tag, ovf: 1'b0, dbz: 1'b0};
  assign sh = in_b[SHW-1:0];
  always_comb begin
    sum = {1'b0, in_a} + {1'b0, in_b};
    diff = {1'b0, in_a} - {1'b0, in_b};
    rl = {in_a, in_a} << sh;
    rr = {in_a, in_a} >> sh;
    alu_ent = '0;
    alu_ent.tag = in_tag;
    case (in_op)
      OP_ADD: begin
        alu_ent.result = zx(sum[WIDTH-1:0]);
        alu_ent.ovf = sum[WIDTH];
      end
      OP_SUB: begin
        alu_ent.result = zx(diff[WIDTH-1:0]);
        alu_ent.ovf = diff[WIDTH];
      end
      OP_MUL: alu_ent.result = zx(in_a) * zx(in_b);
      OP_DIV: begin
        alu_ent.result = {in_a, {WIDTH{1'b1}}};
        alu_ent.dbz = 1'b1;
      end
      OP_SLL: alu_ent.result = zx(in_a << sh);
      OP_SRL: alu_ent.result = zx(in_a >> sh);
      OP_ROL: alu_ent.result = zx(rl[2*WIDTH-1:WIDTH]);
      OP_ROR: alu_ent.result = zx(rr[WIDTH-1:0]);
      OP_AND: alu_ent.result = zx(in_a & in_b);
      OP_OR: alu_ent.result = zx(in_a | in_b);
      OP_XOR: alu_ent.result = zx(in_a ^ in_b);
      OP_NOR: alu_ent.result = zx(~(in_a | in_b));
      OP_NAND: alu_ent.result = zx(~(in_a & in_b));
      OP_XNOR: alu_ent.result = zx(~(in_a ^ in_b));
      OP_GT: alu_ent.result = zx(WIDTH'(in_a > in_b));
      OP_EQ: alu_ent.result = zx(WIDTH'(in_a == in_b));
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= state == DIV_DONE ? div_ent : pend;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pend_valid <= 1'b0;
      pend <= '0;
      div_tag <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      pend_valid <= accept && !div_start;
      if (accept && !div_start) pend <= alu_ent;
      if (div_start) div_tag <= in_tag;
      state <= state == IDLE ? (div_start ? DIV_RUN : IDLE) :
               state == DIV_RUN ? (div_done ? DIV_DONE : DIV_RUN) : IDLE;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: tb/tb_alu_stream_core.sv
// tb_alu_stream_core: directed self-checking bench for alu_stream_core
module tb_alu_stream_core;
  import alu_pkg::*;
  logic clk, reset, in_valid, in_ready, out_valid, out_ready, out_ovf, out_dbz, busy;
  op_e in_op;
  logic [7:0] in_a, in_b;
  logic [3:0] in_tag, out_tag;
  logic [15:0] out_result;
  int total, bad;
  alu_stream_core #(.WIDTH(8), .FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_ovf(out_ovf), .out_dbz(out_dbz), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic issue(input op_e op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag, output logic acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    acc = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic pop_one;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_valid_busy got=%b/%b want=0/0", out_valid, busy); end
    total++; if (out_result !== 16'h0 || out_tag !== 4'h0 || out_ovf !== 1'b0 || out_dbz !== 1'b0) begin bad++; $display("FAIL rst_outputs got=%h/%h/%b/%b want=0", out_result, out_tag, out_ovf, out_dbz); end
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_add;
    logic acc;
    issue(OP_ADD, 8'd200, 8'd100, 4'd3, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL add_accept got=%b want=1", acc); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_early got=%b want=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 16'h002C || out_ovf !== 1'b1 || out_tag !== 4'd3 || out_dbz !== 1'b0)
      begin bad++; $display("FAIL add_result got=%b/%h/%b/%h want=1/002c/1/3", out_valid, out_result, out_ovf, out_tag); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 16'h002C || out_tag !== 4'd3) begin bad++; $display("FAIL add_hold got=%b/%h/%h want=1/002c/3", out_valid, out_result, out_tag); end
    pop_one();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_pop got=%b/%b want=0/0", out_valid, busy); end
  endtask
  task automatic test_ops;
    op_e ops [12];
    logic [7:0] av [12];
    logic [7:0] bv [12];
    logic [15:0] ex [12];
    logic eo [12];
    logic acc;
    ops = '{OP_SUB, OP_EQ, OP_GT, OP_GT, OP_MUL, OP_ROL, OP_SRL, OP_ROR, OP_NAND, OP_XNOR, OP_SLL, OP_NOR};
    av = '{8'h05, 8'h5A, 8'h10, 8'h11, 8'hFF, 8'h81, 8'h80, 8'h01, 8'hFF, 8'hF0, 8'h81, 8'h01};
    bv = '{8'h07, 8'h5A, 8'h11, 8'h10, 8'hFF, 8'h01, 8'h09, 8'h01, 8'h0F, 8'h3C, 8'h03, 8'h02};
    ex = '{16'h00FE, 16'h0001, 16'h0000, 16'h0001, 16'hFE01, 16'h0003, 16'h0040, 16'h0080, 16'h00F0, 16'h0033, 16'h0008, 16'h00FC};
    eo = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], av[i], bv[i], 4'(i), acc);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (acc !== 1'b1 || out_valid !== 1'b1 || out_result !== ex[i] || out_tag !== 4'(i) || out_ovf !== eo[i] || out_dbz !== 1'b0) begin
        bad++;
        $display("FAIL op%0d got acc=%b v=%b r=%h t=%h o=%b d=%b want r=%h t=%h o=%b", i, acc, out_valid, out_result, out_tag, out_ovf, out_dbz, ex[i], 4'(i), eo[i]);
      end
      pop_one();
    end
  endtask
  task automatic test_div;
    logic acc;
    issue(OP_DIV, 8'd200, 8'd7, 4'd5, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL div_accept got=%b want=1", acc); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || (k <= 8 && in_ready !== 1'b0)) begin bad++; $display("FAIL div_wait%0d got v=%b rdy=%b want 0/0", k, out_valid, in_ready); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 16'h041C || out_tag !== 4'd5 || out_dbz !== 1'b0 || out_ovf !== 1'b0)
      begin bad++; $display("FAIL div_result got=%b/%h/%h/%b want=1/041c/5/0", out_valid, out_result, out_tag, out_dbz); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL div_ready_after got=%b want=1", in_ready); end
    pop_one();
  endtask
  task automatic test_div_zero;
    logic acc;
    issue(OP_DIV, 8'h37, 8'h00, 4'd9, acc);
    @(negedge clk);
    total++; if (acc !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL dbz_early got acc=%b v=%b want 1/0", acc, out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_result !== 16'h37FF || out_dbz !== 1'b1 || out_ovf !== 1'b0 || out_tag !== 4'd9)
      begin bad++; $display("FAIL dbz_result got=%b/%h/%b/%h want=1/37ff/1/9", out_valid, out_result, out_dbz, out_tag); end
    pop_one();
  endtask
  task automatic test_back_pressure;
    int acc_n;
    logic rdy;
    acc_n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op = OP_ADD;
      in_a = 8'(i);
      in_b = 8'd1;
      in_tag = 4'(i);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) acc_n++;
    end
    #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (acc_n != 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", acc_n); end
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_full got rdy=%b v=%b want 0/1", in_ready, out_valid); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_comb_ready got=%b want=0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_tag !== 4'(i) || out_result !== 16'(i + 1) || (i == 1 && in_ready !== 1'b1))
        begin bad++; $display("FAIL bp_pop%0d got v=%b t=%h r=%h rdy=%b want t=%h r=%h", i, out_valid, out_tag, out_result, in_ready, 4'(i), 16'(i + 1)); end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_drained got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask
  task automatic test_reset_mid_div;
    logic acc;
    issue(OP_ADD, 8'd1, 8'd1, 4'd1, acc);
    issue(OP_DIV, 8'd200, 8'd7, 4'd2, acc);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_running got b=%b v=%b rdy=%b want 1/1/0", busy, out_valid, in_ready); end
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_result !== 16'h0 || out_tag !== 4'h0)
      begin bad++; $display("FAIL mid_reset got v=%b b=%b rdy=%b r=%h t=%h want 0", out_valid, busy, in_ready, out_result, out_tag); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_release got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    issue(OP_ADD, 8'd3, 8'd4, 4'd6, acc);
    @(negedge clk);
    @(negedge clk);
    total++; if (acc !== 1'b1 || out_valid !== 1'b1 || out_result !== 16'h0007 || out_tag !== 4'd6 || out_ovf !== 1'b0)
      begin bad++; $display("FAIL mid_next got acc=%b v=%b r=%h t=%h want 1/1/0007/6", acc, out_valid, out_result, out_tag); end
    pop_one();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_flushed got v=%b b=%b want 0/0", out_valid, busy); end
  endtask
  initial begin
    total = 0;
    bad = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_op = OP_ADD;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    test_reset();
    test_add();
    test_ops();
    test_div();
    test_div_zero();
    test_back_pressure();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
